imem_prefetch_buffer: RTL and testbench
=======================================

IMEM_PREFETCH_BUFFER -- requirements
Module: imem_prefetch_buffer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the instruction FIFO entries; it must be a power of 2.
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default 2, giving the granted-but-unanswered memory request limit.
REQ-004 The block SHALL have a single clock i_clk; all state changes on its rising edge.
REQ-005 The block SHALL have i_reset (input, 1): synchronous, active-high reset.
REQ-006 The block SHALL have i_enable (input, 1): permits leaving IDLE.
REQ-007 The block SHALL have i_redirect (input, 1) and i_redirect_pc (input, 64): taken branch/jump from downstream.
REQ-008 The block SHALL have o_mem_req (output, 1), o_mem_addr (output, 64) and i_mem_gnt (input, 1): instruction memory request channel.
REQ-009 The block SHALL have i_mem_rvalid (input, 1) and i_mem_rdata (input, 32): in-order response channel with no backpressure.
REQ-010 The block SHALL have o_valid (output, 1), o_instr (output, 32), o_pc (output, 64) and i_ready (input, 1): handshake toward the fetch/IFID stage.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH and FLUSH; reset enters IDLE; IDLE->FETCH when i_enable=1.
REQ-012 A request handshake SHALL complete in a cycle with o_mem_req=1 and i_mem_gnt=1; o_mem_addr stays stable while o_mem_req=1 and i_mem_gnt=0, unless a redirect occurs.
REQ-013 In FETCH, o_mem_req SHALL be 1 iff outstanding<MAX_OUTSTANDING and (fifo_count+outstanding)<DEPTH, so every response has a reserved slot.
REQ-014 On each grant, fetch_pc SHALL advance by 4 (64-bit wrap at 2^64), and (fetch_pc, ordered) SHALL be pushed onto an internal PC queue.
REQ-015 A non-dropped i_mem_rvalid SHALL write {i_mem_rdata, queued pc} into the FIFO that cycle; o_valid is 1 from the next cycle (one-cycle response-to-output latency).
REQ-016 o_instr/o_pc SHALL be the FIFO head, driven combinationally; the head is popped when o_valid=1 and i_ready=1.
REQ-017 A simultaneous push and pop SHALL leave fifo_count unchanged; the FIFO is never overrun (guaranteed by REQ-013).
REQ-018 The outstanding counter SHALL increment on grant and decrement on rvalid; simultaneous grant and rvalid leave it unchanged.
REQ-019 On i_redirect=1 in FETCH or FLUSH, the FIFO and PC queue SHALL be cleared, fetch_pc set to {i_redirect_pc[63:2],2'b00}, and drop_count set to the outstanding count after this cycle's rvalid/grant.
REQ-020 A same-cycle pop SHALL be ignored on redirect, and a same-cycle rvalid SHALL be discarded; o_valid is 0 the next cycle.
REQ-021 On redirect with drop_count>0 the FSM SHALL go to FLUSH, otherwise stay/return to FETCH.
REQ-022 In FLUSH, o_mem_req SHALL be 0, and each rvalid decrements drop_count without writing the FIFO; when drop_count reaches 0, FLUSH->FETCH.
REQ-023 An ungranted pending request SHALL be abandoned on redirect, with o_mem_addr showing the new PC the following cycle.
REQ-024 i_redirect SHALL be ignored in IDLE.

Reset
REQ-025 While i_reset=1, the block SHALL set the state to IDLE, fetch_pc=RESET_PC, fifo_count=0, outstanding=0, drop_count=0 and clear the PC queue.
REQ-026 The block SHALL drive o_valid=0, o_mem_req=0, o_mem_addr=RESET_PC, o_instr=32'h0 and o_pc=64'h0 during reset and in IDLE.
REQ-027 Reset asserted mid-operation SHALL override all other inputs that cycle; responses to pre-reset requests are the environment's responsibility to suppress.

Verification
REQ-028 Streaming: reset, i_enable=1, gnt=1 always, rvalid 1 cycle after grant, i_ready=1 -> o_pc sequence 0,4,8,12 with o_instr matching the rdata, and no bubbles after the first instruction.
REQ-029 Backpressure: i_ready=0 for 10 cycles -> exactly DEPTH=4 instructions buffered, o_mem_req falls to 0, and no FIFO write is lost; i_ready=1 -> pcs 0,4,8,12 in order.
REQ-030 Redirect with 2 outstanding: i_redirect_pc=64'h1003 -> next two rvalids dropped, FLUSH for 2 responses, next o_mem_addr=64'h1000, first o_pc after redirect=64'h1000.
REQ-031 Simultaneous events: redirect in the same cycle as rvalid, pop and grant -> the rvalid is discarded, drop_count accounts for the new grant, and o_valid=0 the next cycle.
REQ-032 Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second request address 64'h0.
REQ-033 Mid-run reset: i_reset asserted with FIFO count 3 -> o_valid=0, o_mem_req=0 and o_mem_addr=RESET_PC the next cycle, and the FSM stays in IDLE until i_enable=1.

Source files
------------

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer: issues in-order fetches to instruction memory, queues
// responses in a small FIFO toward IF/ID, and discards in-flight responses on redirect.
module imem_prefetch_buffer #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [63:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [63:0] o_pc,
  input  logic        i_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [QW-1:0]   pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [OW-1:0]   out_q, out_d, drop_q, drop_d;

  logic [31:0]     fifo_instr_q [DEPTH];
  logic [63:0]     fifo_pc_q    [DEPTH];
  logic [63:0]     pcq_q        [MAX_OUTSTANDING];

  logic req_int, grant, rsp_eff, accept, pop, redirect_act, pcq_we;

  function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [QW-1:0] pcq_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  // Request only when a FIFO slot is reserved for every response already in flight.
  assign req_int = (state_q == FETCH) && (32'(out_q) < MAX_OUTSTANDING) &&
                   ((32'(fifo_cnt_q) + 32'(out_q)) < DEPTH);

  assign o_mem_req    = req_int && !i_reset;
  assign o_mem_addr   = i_reset ? RESET_PC : fetch_pc_q;
  assign grant        = o_mem_req && i_mem_gnt;
  assign redirect_act = i_redirect && (state_q != IDLE);
  assign rsp_eff      = i_mem_rvalid && (state_q != IDLE) && (out_q != '0);
  assign accept       = rsp_eff && (state_q == FETCH) && !redirect_act;
  assign pcq_we       = grant && !redirect_act;

  assign o_valid = !i_reset && (state_q == FETCH) && (fifo_cnt_q != '0);
  assign o_instr = o_valid ? fifo_instr_q[fifo_rd_q] : '0;
  assign o_pc    = o_valid ? fifo_pc_q[fifo_rd_q]    : '0;
  assign pop     = o_valid && i_ready && !redirect_act;

  always_comb begin
    out_d = out_q;
    case ({grant, rsp_eff})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_cnt_d = fifo_cnt_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: if (i_enable) state_d = FETCH;
      FETCH: begin
        if (grant) begin
          fetch_pc_d = fetch_pc_q + 64'd4;
          pcq_wr_d   = pcq_inc(pcq_wr_q);
        end
        if (accept) begin
          fifo_wr_d = fifo_inc(fifo_wr_q);
          pcq_rd_d  = pcq_inc(pcq_rd_q);
        end
        if (pop) fifo_rd_d = fifo_inc(fifo_rd_q);
        case ({accept, pop})
          2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
          2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
          default: fifo_cnt_d = fifo_cnt_q;
        endcase
      end
      FLUSH: begin
        if (rsp_eff) begin
          drop_d = drop_q - OW'(1);
          if (drop_q == OW'(1)) state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // Redirect drops everything queued and whatever is still in flight after this cycle.
    if (redirect_act) begin
      fetch_pc_d = i_redirect_pc & ~64'h3;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      fifo_cnt_d = '0;
      pcq_rd_d   = '0;
      pcq_wr_d   = '0;
      drop_d     = out_d;
      state_d    = (out_d != '0) ? FLUSH : FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      fifo_instr_q[fifo_wr_q] <= i_mem_rdata;
      fifo_pc_q[fifo_wr_q]    <= pcq_q[pcq_rd_q];
    end
    if (pcq_we) pcq_q[pcq_wr_q] <= fetch_pc_q;
  end

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed bench for imem_prefetch_buffer: streaming, backpressure, redirect/flush,
// simultaneous events, address wrap and mid-run reset.
module tb_imem_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset, enable, redirect, mem_gnt, rvalid, ready;
  logic [63:0] redirect_pc;
  logic [31:0] rdata;
  logic        o_mem_req, o_valid, w_mem_req, w_valid;
  logic [63:0] o_mem_addr, o_pc, w_mem_addr, w_pc;
  logic [31:0] o_instr, w_instr;

  int checks = 0;
  int errors = 0;

  logic [63:0] gnt_q[$];
  logic [63:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  bit          hold;

  always #5 clk = ~clk;

  imem_prefetch_buffer u_dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(ready)
  );

  imem_prefetch_buffer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_mem_req(w_mem_req), .o_mem_addr(w_mem_addr),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
    .o_valid(w_valid), .o_instr(w_instr), .o_pc(w_pc), .i_ready(ready)
  );

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return 32'hAB00_0000 ^ a[31:0];
  endfunction

  // One clock: record handshakes before the edge, then drive the memory response 1 cycle later.
  task automatic step();
    logic        g;
    logic [63:0] a;
    g = o_mem_req && mem_gnt;
    a = o_mem_addr;
    if (o_valid && ready) begin
      pop_pc.push_back(o_pc);
      pop_instr.push_back(o_instr);
    end
    @(posedge clk);
    #1;
    if (g) gnt_q.push_back(a);
    if (!hold && gnt_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = data_of(gnt_q.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b0; ready = 1'b0; hold = 1'b0; rvalid = 1'b0; rdata = '0;
    gnt_q.delete();
    step();
    step();
    reset = 1'b0;
    pop_pc.delete();
    pop_instr.delete();
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12 && o_valid !== 1'b1; i++) step();
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout o_valid=%0b expected 1", name, o_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b1; ready = 1'b1; hold = 1'b0; rvalid = 1'b0; rdata = '0;
    step();
    checks++;
    if ({o_valid, o_mem_req} !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl valid/req=%b expected 00", {o_valid, o_mem_req});
    end
    checks++;
    if (o_mem_addr !== 64'h0 || o_pc !== 64'h0 || o_instr !== 32'h0) begin
      errors++; $display("FAIL reset_data addr=%h pc=%h instr=%h expected zeros", o_mem_addr, o_pc, o_instr);
    end
    checks++;
    if (w_mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL reset_pc_param addr=%h expected fffffffffffffffc", w_mem_addr);
    end
    reset = 1'b0; redirect = 1'b1; redirect_pc = 64'h5000;
    repeat (3) step();
    redirect = 1'b0;
    checks++;
    if ({o_valid, o_mem_req} !== 2'b00 || o_mem_addr !== 64'h0) begin
      errors++; $display("FAIL idle_redirect valid/req=%b addr=%h expected 00 / 0", {o_valid, o_mem_req}, o_mem_addr);
    end
  endtask

  task automatic test_streaming();
    logic [63:0] exp_pc [4];
    exp_pc[0] = 64'h0; exp_pc[1] = 64'h4; exp_pc[2] = 64'h8; exp_pc[3] = 64'hC;
    do_reset();
    enable = 1'b1; mem_gnt = 1'b1; ready = 1'b1;
    wait_valid("stream");
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o_valid !== 1'b1) begin
        errors++; $display("FAIL stream_bubble cycle %0d o_valid=%0b expected 1", i, o_valid);
      end
    end
    checks++;
    if (pop_pc.size() !== 4) begin
      errors++; $display("FAIL stream_count pops=%0d expected 4", pop_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_pc[i] !== exp_pc[i] || pop_instr[i] !== data_of(exp_pc[i])) begin
          errors++; $display("FAIL stream_item%0d pc=%h instr=%h expected %h / %h",
                             i, pop_pc[i], pop_instr[i], exp_pc[i], data_of(exp_pc[i]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; mem_gnt = 1'b1; ready = 1'b0;
    repeat (10) step();
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++; $display("FAIL bp_req_stop o_mem_req=%0b expected 0", o_mem_req);
    end
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 64'h0 || o_instr !== 32'hAB00_0000) begin
      errors++; $display("FAIL bp_head valid=%0b pc=%h instr=%h expected 1 / 0 / ab000000", o_valid, o_pc, o_instr);
    end
    ready = 1'b1;
    repeat (4) step();
    checks++;
    if (pop_pc.size() !== 4) begin
      errors++; $display("FAIL bp_drain pops=%0d expected 4", pop_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_pc[i] !== 64'(4 * i)) begin
          errors++; $display("FAIL bp_order%0d pc=%h expected %h", i, pop_pc[i], 64'(4 * i));
        end
      end
    end
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 64'h10) begin
      errors++; $display("FAIL bp_resume valid=%0b pc=%h expected 1 / 10", o_valid, o_pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    enable = 1'b1; mem_gnt = 1'b1; ready = 1'b1; hold = 1'b1;
    repeat (3) step();
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++; $display("FAIL redir_limit o_mem_req=%0b expected 0 with 2 outstanding", o_mem_req);
    end
    redirect = 1'b1; redirect_pc = 64'h1003;
    step();
    redirect = 1'b0;
    pop_pc.delete(); pop_instr.delete();
    checks++;
    if ({o_valid, o_mem_req} !== 2'b00 || o_mem_addr !== 64'h1000) begin
      errors++; $display("FAIL redir_flush valid/req=%b addr=%h expected 00 / 1000", {o_valid, o_mem_req}, o_mem_addr);
    end
    hold = 1'b0;
    step();
    step();
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++; $display("FAIL redir_flush_hold o_mem_req=%0b expected 0 with one drop left", o_mem_req);
    end
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h1000) begin
      errors++; $display("FAIL redir_refetch req=%0b addr=%h expected 1 / 1000", o_mem_req, o_mem_addr);
    end
    wait_valid("redir");
    checks++;
    if (o_pc !== 64'h1000 || o_instr !== 32'hAB00_1000) begin
      errors++; $display("FAIL redir_first pc=%h instr=%h expected 1000 / ab001000", o_pc, o_instr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    enable = 1'b1; mem_gnt = 1'b1; ready = 1'b1;
    wait_valid("simul");
    repeat (2) step();
    checks++;
    if (o_valid !== 1'b1 || o_mem_req !== 1'b1 || rvalid !== 1'b1) begin
      errors++; $display("FAIL simul_pre valid=%0b req=%0b rvalid=%0b expected all 1", o_valid, o_mem_req, rvalid);
    end
    redirect = 1'b1; redirect_pc = 64'h2000;
    step();
    redirect = 1'b0;
    pop_pc.delete(); pop_instr.delete();
    checks++;
    if ({o_valid, o_mem_req} !== 2'b00 || o_mem_addr !== 64'h2000) begin
      errors++; $display("FAIL simul_after valid/req=%b addr=%h expected 00 / 2000", {o_valid, o_mem_req}, o_mem_addr);
    end
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h2000) begin
      errors++; $display("FAIL simul_refetch req=%0b addr=%h expected 1 / 2000", o_mem_req, o_mem_addr);
    end
    wait_valid("simul_post");
    checks++;
    if (o_pc !== 64'h2000 || o_instr !== 32'hAB00_2000) begin
      errors++; $display("FAIL simul_first pc=%h instr=%h expected 2000 / ab002000", o_pc, o_instr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    enable = 1'b1; mem_gnt = 1'b1; ready = 1'b1; hold = 1'b1;
    step();
    checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_first req=%0b addr=%h expected 1 / fffffffffffffffc", w_mem_req, w_mem_addr);
    end
    step();
    checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 64'h0) begin
      errors++; $display("FAIL wrap_second req=%0b addr=%h expected 1 / 0", w_mem_req, w_mem_addr);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    enable = 1'b1; mem_gnt = 1'b1; ready = 1'b0;
    repeat (5) step();
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 64'h0) begin
      errors++; $display("FAIL mid_pre valid=%0b pc=%h expected 1 / 0", o_valid, o_pc);
    end
    reset = 1'b1;
    gnt_q.delete();
    rvalid = 1'b0;
    step();
    reset = 1'b0; enable = 1'b0;
    checks++;
    if ({o_valid, o_mem_req} !== 2'b00 || o_mem_addr !== 64'h0) begin
      errors++; $display("FAIL mid_reset valid/req=%b addr=%h expected 00 / 0", {o_valid, o_mem_req}, o_mem_addr);
    end
    repeat (3) step();
    checks++;
    if ({o_valid, o_mem_req} !== 2'b00) begin
      errors++; $display("FAIL mid_idle valid/req=%b expected 00", {o_valid, o_mem_req});
    end
    enable = 1'b1;
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h0) begin
      errors++; $display("FAIL mid_restart req=%0b addr=%h expected 1 / 0", o_mem_req, o_mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_simultaneous();
    test_wrap();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
